// File: rtl/button_pkg.sv
// Shared state encoding, default 16 MHz timing constants and a sizing helper
// for the button event decoder.
package button_pkg;

  typedef enum logic [2:0] {
    ST_ARM       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PRESSED   = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_WAIT2     = 3'd4,
    ST_PRESSED2  = 3'd5
  } state_e;

  localparam int unsigned LONG_500MS   = 8_000_000;
  localparam int unsigned REPEAT_100MS = 1_600_000;
  localparam int unsigned DBL_250MS    = 4_000_000;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Polarity mapping, one-cycle level register and press/release edge strobes.
module btn_edge #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_btn,
  output logic o_lvl_c,
  output logic o_level,
  output logic o_pe_c,
  output logic o_ne_c
);

  logic r_prev;

  assign o_lvl_c = i_btn ^ ACTIVE_LOW;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_prev <= 1'b0;
    else          r_prev <= o_lvl_c;
  end

  assign o_level = r_prev;
  assign o_pe_c  = o_lvl_c & ~r_prev;
  assign o_ne_c  = ~o_lvl_c & r_prev;

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press/release/click,
// double-click, long-press and auto-repeat pulses using cycle counting.
module button_events
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_500MS,
  parameter int unsigned REPEAT_CYCLES = REPEAT_100MS,
  parameter int unsigned DBL_CYCLES    = DBL_250MS,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic btn_in,
  output logic pressed,
  output logic press,
  output logic release_evt,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_evt
);

  localparam int unsigned CNT_MAX = max3(LONG_CYCLES, REPEAT_CYCLES, DBL_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned DBL_M1  = (DBL_CYCLES == 0) ? 0 : DBL_CYCLES - 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_M1);

  logic w_lvl;
  logic w_pe;
  logic w_ne;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;

  btn_edge #(.ACTIVE_LOW(ACTIVE_LOW)) u_edge (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_btn   (btn_in),
    .o_lvl_c (w_lvl),
    .o_level (pressed),
    .o_pe_c  (w_pe),
    .o_ne_c  (w_ne)
  );

  // Event FSM: pulses default low, counter restarts on every state entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_ARM;
      r_cnt        <= '0;
      press        <= 1'b0;
      release_evt  <= 1'b0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_evt   <= 1'b0;
    end else begin
      press        <= 1'b0;
      release_evt  <= 1'b0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_evt   <= 1'b0;
      r_cnt        <= r_cnt + CW'(1);
      unique case (r_state)
        ST_ARM: begin
          r_cnt <= '0;
          if (!w_lvl) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_pe) begin
            press   <= 1'b1;
            r_state <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (w_ne) begin
            release_evt <= 1'b1;
            r_cnt       <= '0;
            if (DBL_CYCLES == 0) begin
              click   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT2;
            end
          end else if (r_cnt == LONG_LAST) begin
            long_press <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_LONG_HELD;
          end
        end
        ST_LONG_HELD: begin
          if (w_ne) begin
            release_evt <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_IDLE;
          end else if (r_cnt == REP_LAST) begin
            repeat_evt <= 1'b1;
            r_cnt      <= '0;
          end
        end
        // A second press beats a coincident window timeout.
        ST_WAIT2: begin
          if (w_pe) begin
            press   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_PRESSED2;
          end else if (r_cnt == DBL_LAST) begin
            click   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_PRESSED2: begin
          if (w_ne) begin
            release_evt  <= 1'b1;
            double_click <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ST_IDLE;
          end else if (r_cnt == LONG_LAST) begin
            click      <= 1'b1;
            long_press <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_LONG_HELD;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_ARM;
        end
      endcase
    end
  end

endmodule
